// File: rtl/acc_mem_order_pkg.sv
// acc_mem_order_pkg
//  Shared types and defaults for the accelerator memory-ordering controller.
//  - acc_ord_state_e : ordering FSM state (RUN, BLOCK, FLUSH)
//  - ACC_MAX_OUTSTANDING_DEF : default in-flight limit per op class
package acc_mem_order_pkg;

  localparam int ACC_MAX_OUTSTANDING_DEF = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    BLOCK = 2'd1,
    FLUSH = 2'd2
  } acc_ord_state_e;

endpackage

// File: rtl/acc_outstanding_cnt.sv
// acc_outstanding_cnt
//  Saturating up/down counter of dispatched-but-incomplete accelerator ops.
//  A dispatch at MAX or a completion at zero is dropped and flagged on err_o
//  for one cycle; a dispatch and completion in the same cycle cancel out.
//  Ports:
//   clk_i       in   clock
//   rst_i       in   asynchronous active-high reset
//   disp_i      in   op dispatched this cycle
//   complete_i  in   op completed this cycle
//   cnt_o       out  registered in-flight count
//   err_o       out  combinational protocol-violation pulse
module acc_outstanding_cnt #(
  parameter int MAX = 8,
  parameter int W   = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         disp_i,
  input  logic         complete_i,
  output logic [W-1:0] cnt_o,
  output logic         err_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_reg;
  logic         inc;
  logic         dec;
  logic         at_max;
  logic         at_zero;

  always_comb begin
    inc     = disp_i & ~complete_i;
    dec     = complete_i & ~disp_i;
    at_max  = (cnt_reg == MAX_V);
    at_zero = (cnt_reg == '0);
    err_o   = (inc & at_max) | (dec & at_zero);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (inc && !at_max) begin
      cnt_reg <= cnt_reg + W'(1);
    end else if (dec && !at_zero) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/acc_mem_order_ctrl.sv
// acc_mem_order_ctrl
//  Orders CPU load/store issue against outstanding accelerator (CVXIF) memory
//  ops. Tracks in-flight accelerator loads and stores, gates the issue->LSU
//  valid/ready handshake while consistency is enforced, and holds off new
//  accelerator dispatch while a flush drains the counters.
//  Optional feature: define ACC_MEM_ORDER_PERF_EN to add stall_cycles_o, a
//  saturating count of cycles with mem_stall_o=1.
//  Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               pipeline flush
//   acc_cons_en_i         enforce memory consistency
//   acc_ld/st_disp_i      accelerator load/store dispatched
//   acc_ld/st_complete_i  accelerator load/store completed
//   acc_disp_ready_o      [0] load dispatch allowed, [1] store dispatch allowed
//   issue_lsu_valid_i     CPU memory op presented
//   issue_is_store_i      1=store/AMO, 0=load
//   issue_lsu_ready_o     CPU op accepted toward LSU
//   lsu_valid_o           gated valid to LSU
//   lsu_ready_i           LSU ready
//   mem_stall_o           CPU op held back by ordering
//   acc_idle_o            no accelerator ops in flight
//   stall_cycles_o        (ACC_MEM_ORDER_PERF_EN only) stall cycle count
//   proto_err_o           sticky counter over/underflow flag
module acc_mem_order_ctrl
  import acc_mem_order_pkg::*;
#(
  parameter int MAX_OUTSTANDING = ACC_MAX_OUTSTANDING_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        acc_cons_en_i,
  input  logic        acc_ld_disp_i,
  input  logic        acc_st_disp_i,
  input  logic        acc_ld_complete_i,
  input  logic        acc_st_complete_i,
  output logic [1:0]  acc_disp_ready_o,
  input  logic        issue_lsu_valid_i,
  input  logic        issue_is_store_i,
  output logic        issue_lsu_ready_o,
  output logic        lsu_valid_o,
  input  logic        lsu_ready_i,
  output logic        mem_stall_o,
  output logic        acc_idle_o,
`ifdef ACC_MEM_ORDER_PERF_EN
  output logic [31:0] stall_cycles_o,
`endif
  output logic        proto_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] ld_cnt;
  logic [CNT_W-1:0] st_cnt;
  logic             ld_err;
  logic             st_err;
  logic             allow;
  acc_ord_state_e   state_reg;
  logic             proto_err_reg;

  acc_outstanding_cnt #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_ld_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .disp_i     (acc_ld_disp_i),
    .complete_i (acc_ld_complete_i),
    .cnt_o      (ld_cnt),
    .err_o      (ld_err)
  );

  acc_outstanding_cnt #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_st_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .disp_i     (acc_st_disp_i),
    .complete_i (acc_st_complete_i),
    .cnt_o      (st_cnt),
    .err_o      (st_err)
  );

  // Loads only have to wait for accelerator stores; stores wait for both.
  // FLUSH blocks everything regardless of the enable, so a drain is never
  // overtaken by new CPU traffic. Counters are registered, so a completion
  // releases the CPU op one cycle later.
  always_comb begin
    allow = 1'b1;
    if (state_reg == FLUSH) begin
      allow = 1'b0;
    end else if (acc_cons_en_i) begin
      if (issue_is_store_i) begin
        allow = (st_cnt == '0) && (ld_cnt == '0);
      end else begin
        allow = (st_cnt == '0);
      end
    end
  end

  always_comb begin
    acc_idle_o          = (ld_cnt == '0) && (st_cnt == '0);
    acc_disp_ready_o[0] = (ld_cnt < MAX_V) && (state_reg != FLUSH);
    acc_disp_ready_o[1] = (st_cnt < MAX_V) && (state_reg != FLUSH);
    lsu_valid_o         = issue_lsu_valid_i & allow;
    issue_lsu_ready_o   = lsu_ready_i & allow;
    mem_stall_o         = issue_lsu_valid_i & ~allow;
    proto_err_o         = proto_err_reg;
  end

  // BLOCK carries no functional difference from RUN; it only marks stalled
  // periods. flush_i is ignored once in FLUSH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= RUN;
      proto_err_reg <= 1'b0;
    end else begin
      proto_err_reg <= proto_err_reg | ld_err | st_err;
      case (state_reg)
        RUN, BLOCK: begin
          if (flush_i) begin
            state_reg <= acc_idle_o ? RUN : FLUSH;
          end else if (state_reg == RUN) begin
            if (issue_lsu_valid_i && !allow) state_reg <= BLOCK;
          end else begin
            if (allow || !issue_lsu_valid_i) state_reg <= RUN;
          end
        end
        FLUSH: begin
          if (acc_idle_o) state_reg <= RUN;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

`ifdef ACC_MEM_ORDER_PERF_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_reg <= '0;
    end else if (mem_stall_o && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_acc_mem_order_ctrl.sv
module tb_acc_mem_order_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        acc_cons_en_i;
  logic        acc_ld_disp_i;
  logic        acc_st_disp_i;
  logic        acc_ld_complete_i;
  logic        acc_st_complete_i;
  logic [1:0]  acc_disp_ready_o;
  logic        issue_lsu_valid_i;
  logic        issue_is_store_i;
  logic        issue_lsu_ready_o;
  logic        lsu_valid_o;
  logic        lsu_ready_i;
  logic        mem_stall_o;
  logic        acc_idle_o;
  logic        proto_err_o;
`ifdef ACC_MEM_ORDER_PERF_EN
  logic [31:0] stall_cycles_o;
`endif

  int checks_cnt = 0;
  int fail_cnt   = 0;

  always #5 clk_i = ~clk_i;

  acc_mem_order_ctrl dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .flush_i           (flush_i),
    .acc_cons_en_i     (acc_cons_en_i),
    .acc_ld_disp_i     (acc_ld_disp_i),
    .acc_st_disp_i     (acc_st_disp_i),
    .acc_ld_complete_i (acc_ld_complete_i),
    .acc_st_complete_i (acc_st_complete_i),
    .acc_disp_ready_o  (acc_disp_ready_o),
    .issue_lsu_valid_i (issue_lsu_valid_i),
    .issue_is_store_i  (issue_is_store_i),
    .issue_lsu_ready_o (issue_lsu_ready_o),
    .lsu_valid_o       (lsu_valid_o),
    .lsu_ready_i       (lsu_ready_i),
    .mem_stall_o       (mem_stall_o),
    .acc_idle_o        (acc_idle_o),
`ifdef ACC_MEM_ORDER_PERF_EN
    .stall_cycles_o    (stall_cycles_o),
`endif
    .proto_err_o       (proto_err_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    acc_cons_en_i = 1'b0;
    acc_ld_disp_i = 1'b0;
    acc_st_disp_i = 1'b0;
    acc_ld_complete_i = 1'b0;
    acc_st_complete_i = 1'b0;
    issue_lsu_valid_i = 1'b0;
    issue_is_store_i = 1'b0;
    lsu_ready_i = 1'b0;
    tick(2);
    rst_i = 1'b0;
    tick();

    // 1. Reset in the middle of traffic (ld_cnt=3)
    acc_ld_disp_i = 1'b1;
    tick(3);
    acc_ld_disp_i = 1'b0;
    check_val("pre_rst_idle", 32'(acc_idle_o), 32'd0);
    rst_i = 1'b1;
    tick();
    check_val("rst_idle", 32'(acc_idle_o), 32'd1);
    check_val("rst_ready", 32'(acc_disp_ready_o), 32'd3);
    check_val("rst_proto_err", 32'(proto_err_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // 2. CPU load waits for an accelerator store
    acc_cons_en_i = 1'b1;
    acc_st_disp_i = 1'b1;
    tick();
    acc_st_disp_i = 1'b0;
    issue_lsu_valid_i = 1'b1;
    issue_is_store_i = 1'b0;
    lsu_ready_i = 1'b1;
    #1;
    check_val("ld_vs_st_valid", 32'(lsu_valid_o), 32'd0);
    check_val("ld_vs_st_stall", 32'(mem_stall_o), 32'd1);
    check_val("ld_vs_st_rdy", 32'(issue_lsu_ready_o), 32'd0);
    tick();
    acc_st_complete_i = 1'b1;
    #1;
    check_val("ld_vs_st_cmpl_cyc", 32'(lsu_valid_o), 32'd0);
    tick();
    acc_st_complete_i = 1'b0;
    check_val("ld_vs_st_release", 32'(lsu_valid_o), 32'd1);
    check_val("ld_vs_st_rdy_rel", 32'(issue_lsu_ready_o), 32'd1);
    check_val("ld_vs_st_nostall", 32'(mem_stall_o), 32'd0);
    issue_lsu_valid_i = 1'b0;
    tick();

    // 3. CPU store waits for two accelerator loads
    acc_ld_disp_i = 1'b1;
    tick(2);
    acc_ld_disp_i = 1'b0;
    issue_lsu_valid_i = 1'b1;
    issue_is_store_i = 1'b0;
    #1;
    check_val("ld_vs_ld_pass", 32'(lsu_valid_o), 32'd1);
    issue_is_store_i = 1'b1;
    #1;
    check_val("st_vs_ld_block", 32'(lsu_valid_o), 32'd0);
    acc_ld_complete_i = 1'b1;
    tick();
    check_val("st_vs_ld_one_left", 32'(lsu_valid_o), 32'd0);
    tick();
    acc_ld_complete_i = 1'b0;
    check_val("st_vs_ld_release", 32'(lsu_valid_o), 32'd1);
    issue_lsu_valid_i = 1'b0;
    acc_cons_en_i = 1'b0;
    acc_ld_disp_i = 1'b1;
    tick(2);
    acc_ld_disp_i = 1'b0;
    issue_lsu_valid_i = 1'b1;
    #1;
    check_val("st_nocons_pass", 32'(lsu_valid_o), 32'd1);
    check_val("st_nocons_stall", 32'(mem_stall_o), 32'd0);
    acc_cons_en_i = 1'b1;
    #1;
    check_val("cons_toggle_block", 32'(lsu_valid_o), 32'd0);
    issue_lsu_valid_i = 1'b0;
    acc_ld_complete_i = 1'b1;
    tick(2);
    acc_ld_complete_i = 1'b0;
    check_val("drain_idle", 32'(acc_idle_o), 32'd1);

    // 4. Saturation and protocol errors
    acc_ld_disp_i = 1'b1;
    tick(7);
    check_val("sat7_ready", 32'(acc_disp_ready_o), 32'd3);
    tick();
    acc_ld_disp_i = 1'b0;
    check_val("sat8_ready", 32'(acc_disp_ready_o), 32'd2);
    check_val("sat8_noerr", 32'(proto_err_o), 32'd0);
    acc_ld_disp_i = 1'b1;
    tick();
    acc_ld_disp_i = 1'b0;
    check_val("ovf_err", 32'(proto_err_o), 32'd1);
    check_val("ovf_ready", 32'(acc_disp_ready_o), 32'd2);
    acc_ld_complete_i = 1'b1;
    tick(7);
    check_val("ovf_cnt_not9_a", 32'(acc_idle_o), 32'd0);
    tick();
    acc_ld_complete_i = 1'b0;
    check_val("ovf_cnt_is8", 32'(acc_idle_o), 32'd1);
    check_val("err_sticky", 32'(proto_err_o), 32'd1);
    do_reset();
    check_val("err_cleared", 32'(proto_err_o), 32'd0);
    acc_st_complete_i = 1'b1;
    tick();
    acc_st_complete_i = 1'b0;
    check_val("udf_err", 32'(proto_err_o), 32'd1);
    check_val("udf_idle", 32'(acc_idle_o), 32'd1);
    do_reset();

    // 5. Simultaneous disp/complete, then flush sequencing
    acc_ld_disp_i = 1'b1;
    tick(4);
    acc_ld_complete_i = 1'b1;
    tick();
    acc_ld_disp_i = 1'b0;
    tick(3);
    check_val("simul_cnt_gt3", 32'(acc_idle_o), 32'd0);
    tick();
    acc_ld_complete_i = 1'b0;
    check_val("simul_cnt_is4", 32'(acc_idle_o), 32'd1);
    check_val("simul_noerr", 32'(proto_err_o), 32'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_val("flush_idle_run", 32'(acc_disp_ready_o), 32'd3);
    acc_st_disp_i = 1'b1;
    tick();
    acc_st_disp_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    acc_cons_en_i = 1'b0;
    issue_lsu_valid_i = 1'b1;
    issue_is_store_i = 1'b0;
    #1;
    check_val("flush_ready", 32'(acc_disp_ready_o), 32'd0);
    check_val("flush_valid", 32'(lsu_valid_o), 32'd0);
    check_val("flush_stall", 32'(mem_stall_o), 32'd1);
    acc_st_complete_i = 1'b1;
    tick();
    acc_st_complete_i = 1'b0;
    check_val("flush_drained", 32'(acc_idle_o), 32'd1);
    tick();
    check_val("flush_exit_ready", 32'(acc_disp_ready_o), 32'd3);
    check_val("flush_exit_valid", 32'(lsu_valid_o), 32'd1);
    issue_lsu_valid_i = 1'b0;
    tick();

`ifdef ACC_MEM_ORDER_PERF_EN
    // 6. Stall cycle counter
    do_reset();
    check_val("perf_rst", stall_cycles_o, 32'd0);
    acc_cons_en_i = 1'b1;
    acc_st_disp_i = 1'b1;
    tick();
    acc_st_disp_i = 1'b0;
    issue_lsu_valid_i = 1'b1;
    issue_is_store_i = 1'b0;
    tick(5);
    issue_lsu_valid_i = 1'b0;
    check_val("perf_5", stall_cycles_o, 32'd5);
    tick();
    check_val("perf_hold", stall_cycles_o, 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
